// File: rtl/h264recon_pkg.sv
// h264recon_pkg: shared constants, row type and clip helper for the 4x4 reconstruction stage.
package h264recon_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
  localparam int unsigned CLIP_W  = 16;

  // One row of four 8-bit pixels, lane0 in the low byte.
  typedef logic [LANES-1:0][PIX_W-1:0] pix_row_t;

  // Saturate a signed sample to the 0..255 pixel range.
  function automatic logic [PIX_W-1:0] clip8(input logic signed [31:0] v);
    logic [PIX_W-1:0] r;
    r = v[PIX_W-1:0];
    if (v < 0) begin
      r = '0;
    end else if (v > 32'sd255) begin
      r = '1;
    end
    return r;
  endfunction

endpackage

// File: rtl/h264recon4x4_if.sv
// h264recon4x4_if: base/residual input and reconstructed output bundle of the recon stage.
interface h264recon4x4_if
  import h264recon_pkg::*;
#(
  parameter int unsigned BDEPTH = 16,
  parameter int unsigned RESW   = 10
);

  localparam int unsigned LW = $clog2(BDEPTH) + 1;

  logic                    NEWSLICE;
  logic                    BSTROBEI;
  pix_row_t                BASEI;
  logic                    STROBEI;
  logic [LANES*RESW-1:0]   DATAI;
  logic                    BREADY;
  logic [LW-1:0]           BLEVEL;
  logic                    FBSTROBE;
  pix_row_t                FEEDB;
  logic                    BLKDONE;
  logic [ERR_W-1:0]        ERR;
  logic [CLIP_W-1:0]       CLIPCNT;

  // Upstream side: drives base rows and residuals, observes the result.
  modport master (
    output NEWSLICE, BSTROBEI, BASEI, STROBEI, DATAI,
    input  BREADY, BLEVEL, FBSTROBE, FEEDB, BLKDONE, ERR, CLIPCNT
  );

  // Reconstruction stage side.
  modport slave (
    input  NEWSLICE, BSTROBEI, BASEI, STROBEI, DATAI,
    output BREADY, BLEVEL, FBSTROBE, FEEDB, BLKDONE, ERR, CLIPCNT
  );

endinterface

// File: rtl/h264recon_fifo.sv
// h264recon_fifo: synchronous row FIFO with occupancy, flush and overflow/underflow detect.
module h264recon_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_nxt_c,
  output logic                     pop_ok_c,
  output logic                     ovf_c,
  output logic                     udf_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full_c;
  logic             empty_c;
  logic             push_ok_c;

  // Accept/reject decisions; a flush suppresses both directions.
  always_comb begin
    full_c    = (level == LW'(DEPTH));
    empty_c   = (level == '0);
    push_ok_c = push && !clr && !full_c;
    pop_ok_c  = pop  && !clr && !empty_c;
    ovf_c     = push && !clr && full_c;
    udf_c     = pop  && !clr && empty_c;
    rdata_c   = mem[rd_ptr];
  end

  // Occupancy after this edge.
  always_comb begin
    level_nxt_c = level;
    if (clr) begin
      level_nxt_c = '0;
    end else begin
      case ({push_ok_c, pop_ok_c})
        2'b10:   level_nxt_c = level + LW'(1);
        2'b01:   level_nxt_c = level - LW'(1);
        default: level_nxt_c = level;
      endcase
    end
  end

  // Pointer and level registers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_nxt_c;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Row storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/h264recon4x4.sv
// h264recon4x4: buffers predicted rows, adds residual rows, clips and returns reconstructed rows.
// Optional clip statistics: define H264RECON_CLIPSTAT_EN to build the CLIPCNT counter.
module h264recon4x4
  import h264recon_pkg::*;
#(
  parameter int unsigned BDEPTH = 16,
  parameter int unsigned RESW   = 10
) (
  input  logic           CLK,
  input  logic           RESET,
  h264recon4x4_if.slave  bus
);

  localparam int unsigned LW = $clog2(BDEPTH) + 1;
  localparam int unsigned SW = RESW + 2;

  logic [LANES*PIX_W-1:0] rdata_c;
  pix_row_t               base_c;
  logic [LW-1:0]          level_nxt_c;
  logic                   pop_ok_c;
  logic                   ovf_c;
  logic                   udf_c;
  logic signed [SW-1:0]   sum_c [LANES];
  pix_row_t               recon_c;
  logic [ERR_W-1:0]       err_set_c;
  logic [1:0]             row_cnt;

  h264recon_fifo #(
    .DEPTH (BDEPTH),
    .WIDTH (LANES*PIX_W)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .clr         (bus.NEWSLICE),
    .push        (bus.BSTROBEI),
    .pop         (bus.STROBEI),
    .wdata       (bus.BASEI),
    .rdata_c     (rdata_c),
    .level       (bus.BLEVEL),
    .level_nxt_c (level_nxt_c),
    .pop_ok_c    (pop_ok_c),
    .ovf_c       (ovf_c),
    .udf_c       (udf_c)
  );

  assign base_c = rdata_c;

  // Per-lane base + sign-extended residual, then clip to the pixel range.
  always_comb begin
    recon_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c[i] = $signed({{(SW-PIX_W){1'b0}}, base_c[i]})
               + $signed({{2{bus.DATAI[i*RESW + RESW-1]}}, bus.DATAI[i*RESW +: RESW]});
      recon_c[i] = clip8(32'(sum_c[i]));
    end
    err_set_c          = '0;
    err_set_c[ERR_OVF] = ovf_c;
    err_set_c[ERR_UDF] = udf_c;
  end

  // Output row, block marker, sticky errors, row counter and headroom flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.FBSTROBE <= 1'b0;
      bus.FEEDB    <= '0;
      bus.BLKDONE  <= 1'b0;
      bus.ERR      <= '0;
      bus.BREADY   <= 1'b1;
      row_cnt      <= '0;
    end else begin
      bus.FBSTROBE <= pop_ok_c;
      bus.BLKDONE  <= pop_ok_c && (row_cnt == 2'd3);
      bus.BREADY   <= (level_nxt_c <= LW'(BDEPTH - 4));
      if (pop_ok_c) bus.FEEDB <= recon_c;
      if (bus.NEWSLICE) begin
        bus.ERR <= '0;
        row_cnt <= '0;
      end else begin
        bus.ERR <= bus.ERR | err_set_c;
        if (pop_ok_c) row_cnt <= row_cnt + 2'd1;
      end
    end
  end

`ifdef H264RECON_CLIPSTAT_EN
  logic [2:0]        sat_cnt_c;
  logic [CLIP_W:0]   clip_sum_c;

  // Count lanes whose sum left 0..255.
  always_comb begin
    sat_cnt_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_cnt_c = sat_cnt_c + 3'(sum_c[i][SW-1] || (|sum_c[i][SW-2:PIX_W]));
    end
    clip_sum_c = (CLIP_W+1)'(bus.CLIPCNT) + (CLIP_W+1)'(sat_cnt_c);
  end

  // Saturating clip statistics counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.CLIPCNT <= '0;
    end else if (bus.NEWSLICE) begin
      bus.CLIPCNT <= '0;
    end else if (pop_ok_c) begin
      bus.CLIPCNT <= clip_sum_c[CLIP_W] ? '1 : clip_sum_c[CLIP_W-1:0];
    end
  end
`else
  assign bus.CLIPCNT = '0;
`endif

endmodule

// File: tb/tb_h264recon4x4.sv
// tb_h264recon4x4: directed plus random stimulus against a queue-based reference model.
module tb_h264recon4x4;

  localparam int unsigned BDEPTH = 16;
  localparam int unsigned RESW   = 10;
  localparam int unsigned DW     = 4*RESW;

  logic CLK;
  logic RESET;

  h264recon4x4_if #(.BDEPTH(BDEPTH), .RESW(RESW)) bus();

  h264recon4x4 #(.BDEPTH(BDEPTH), .RESW(RESW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_err;

  // reference model state
  logic [31:0] q[$];
  int          m_rc;
  logic [1:0]  m_err;
  int          m_clip;
  logic        m_fb;
  logic        m_blk;
  logic [31:0] m_feedb;
  logic [31:0] pushed [17];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] res4(input int r0, input int r1, input int r2, input int r3);
    logic [DW-1:0] d;
    d = '0;
    d[0*RESW +: RESW] = RESW'(r0);
    d[1*RESW +: RESW] = RESW'(r1);
    d[2*RESW +: RESW] = RESW'(r2);
    d[3*RESW +: RESW] = RESW'(r3);
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rc = 0; m_err = 2'b00; m_clip = 0;
    m_fb = 1'b0; m_blk = 1'b0; m_feedb = 32'h0;
  endtask

  // Behaviour of one clock edge given the inputs presented before it.
  task automatic model_step(input logic ns, input logic bp, input logic [31:0] b,
                            input logic sp, input logic [DW-1:0] d);
    int lvl, s, r, sat;
    logic [31:0] row;
    m_fb = 1'b0;
    m_blk = 1'b0;
    if (ns) begin
      q.delete();
      m_rc = 0; m_err = 2'b00; m_clip = 0;
    end else begin
      lvl = q.size();
      if (bp && lvl == int'(BDEPTH)) m_err[0] = 1'b1;
      if (sp && lvl == 0) m_err[1] = 1'b1;
      if (sp && lvl > 0) begin
        row = q.pop_front();
        sat = 0;
        for (int i = 0; i < 4; i++) begin
          r = int'(d[i*RESW +: RESW]);
          if (r >= (1 << (RESW-1))) r -= (1 << RESW);
          s = int'(row[i*8 +: 8]) + r;
          if (s < 0) begin s = 0; sat++; end
          else if (s > 255) begin s = 255; sat++; end
          m_feedb[i*8 +: 8] = 8'(s);
        end
        m_fb = 1'b1;
        m_rc = (m_rc + 1) % 4;
        m_blk = (m_rc == 0);
`ifdef H264RECON_CLIPSTAT_EN
        m_clip = (m_clip + sat > 65535) ? 65535 : m_clip + sat;
`endif
      end
      if (bp && lvl < int'(BDEPTH)) q.push_back(b);
    end
  endtask

  task automatic check_all();
    check("fbstrobe", 32'(bus.FBSTROBE), 32'(m_fb));
    check("feedb",    bus.FEEDB,         m_feedb);
    check("blkdone",  32'(bus.BLKDONE),  32'(m_blk));
    check("err",      32'(bus.ERR),      32'(m_err));
    check("blevel",   32'(bus.BLEVEL),   32'(q.size()));
    check("bready",   32'(bus.BREADY),   32'(q.size() <= int'(BDEPTH) - 4));
    check("clipcnt",  32'(bus.CLIPCNT),  32'(m_clip));
  endtask

  task automatic step(input logic ns, input logic bp, input logic [31:0] b,
                      input logic sp, input logic [DW-1:0] d);
    @(negedge CLK);
    bus.NEWSLICE = ns;
    bus.BSTROBEI = bp;
    bus.BASEI    = b;
    bus.STROBEI  = sp;
    bus.DATAI    = d;
    model_step(ns, bp, b, sp, d);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] b);
    step(1'b0, 1'b1, b, 1'b0, '0);
  endtask

  task automatic pop(input logic [DW-1:0] d);
    step(1'b0, 1'b0, 32'h0, 1'b1, d);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.NEWSLICE = 1'b0; bus.BSTROBEI = 1'b0; bus.BASEI = '0;
    bus.STROBEI = 1'b0; bus.DATAI = '0;
    model_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // reset state after idling
    repeat (5) idle();
    check("rst_bready", 32'(bus.BREADY), 32'd1);
    check("rst_feedb", bus.FEEDB, 32'h0);

    // basic add/clip
    push(32'h80808080);
    pop(res4(5, -3, 0, 127));
    check("t2_fbstrobe", 32'(bus.FBSTROBE), 32'd1);
    check("t2_feedb", bus.FEEDB, 32'hFF807D85);
    check("t2_clipcnt", 32'(bus.CLIPCNT), 32'd0);

    // saturation both ways
    push(32'h05FA0000);
    pop(res4(-1, -1, 10, -10));
    check("t3_feedb", bus.FEEDB, 32'h00FF0000);
`ifdef H264RECON_CLIPSTAT_EN
    check("t3_clipcnt", 32'(bus.CLIPCNT), 32'd4);
`else
    check("t3_clipcnt", 32'(bus.CLIPCNT), 32'd0);
`endif

    // fill past full, then drain in order
    for (int i = 0; i < 17; i++) begin
      pushed[i] = $urandom();
      push(pushed[i]);
      if (i == 11) check("bready_at12", 32'(bus.BREADY), 32'd1);
      if (i == 12) check("bready_at13", 32'(bus.BREADY), 32'd0);
    end
    check("ovf_err0", 32'(bus.ERR[0]), 32'd1);
    check("ovf_level", 32'(bus.BLEVEL), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop('0);
      check("drain_order", bus.FEEDB, pushed[i]);
    end

    // underflow, then a clean block
    step(1'b1, 1'b0, 32'h0, 1'b0, '0);
    pop('0);
    check("udf_fb", 32'(bus.FBSTROBE), 32'd0);
    check("udf_err", 32'(bus.ERR), 32'd2);
    for (int i = 0; i < 4; i++) begin
      push($urandom());
      pop(res4(int'($urandom_range(0, 1023)), 3, -3, 0));
      check("blk_pair", 32'(bus.BLKDONE), 32'(i == 3));
    end

    // flush mid-block restarts the row count
    push(32'h11223344); push(32'h55667788); push(32'h99AABBCC);
    pop('0); pop('0);
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, '0);
    check("ns_level", 32'(bus.BLEVEL), 32'd0);
    check("ns_err", 32'(bus.ERR), 32'd0);
    for (int i = 0; i < 4; i++) begin
      push($urandom());
      pop(res4(-200, 200, -512, 511));
      check("ns_blk", 32'(bus.BLKDONE), 32'(i == 3));
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, $urandom(),
           $urandom_range(0, 1) == 1,
           res4(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))));
    end

    // asynchronous reset mid-block
    push(32'h01020304); push(32'h05060708); pop('0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    model_reset();
    check("arst_level", 32'(bus.BLEVEL), 32'd0);
    check("arst_fb", 32'(bus.FBSTROBE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    pop('0);
    check("arst_udf", 32'(bus.ERR), 32'd2);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
